// File: rtl/ec_stream_pkg.sv
// Shared encodings and default sizing for the EC stream controller.
package ec_stream_pkg;

   typedef enum logic [1:0] {
      MODE_CORRECT  = 2'd0,
      MODE_DETECT   = 2'd1,
      MODE_BYPASS   = 2'd2,
      MODE_DROP_BAD = 2'd3
   } ec_mode_e;

   localparam int FLG_COR    = 0;
   localparam int FLG_NONCOR = 1;
   localparam int FLG_MAL    = 2;

   localparam int DEF_NUM_DIGS   = 10;
   localparam int DEF_DIG_W      = 18;
   localparam int DEF_CORE_LAT   = 86;
   localparam int DEF_FIFO_DEPTH = 128;
   localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/ec_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; the caller guarantees no write when full.
module ec_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     aclr_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_rd;

   assign w_rd = i_rd_en & (r_count != '0);

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd)    r_rd_ptr <= r_rd_ptr + AW'(1);
         if (i_wr_en && !w_rd)      r_count <= r_count + (AW+1)'(1);
         else if (!i_wr_en && w_rd) r_count <= r_count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

endmodule

// File: rtl/ec_correct_stream_ctrl.sv
// Stream wrapper around a non-stallable, fixed-latency RNS error-correction core:
// credit-gated input, matched raw/mode delay line, per-mode output select, stats.
module ec_correct_stream_ctrl
   import ec_stream_pkg::*;
#(
   parameter int NUM_DIGS   = DEF_NUM_DIGS,
   parameter int DIG_W      = DEF_DIG_W,
   parameter int CORE_LAT   = DEF_CORE_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         aclr_n,
   input  logic [1:0]                   mode,
   input  logic                         clr_stats,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_DIGS*DIG_W-1:0]    in_digs,
   output logic                         core_valid,
   output logic [NUM_DIGS*DIG_W-1:0]    core_digs,
   input  logic                         core_valid_out,
   input  logic [NUM_DIGS*DIG_W-1:0]    core_out_digs,
   input  logic                         core_cor_error,
   input  logic                         core_non_cor_error,
   input  logic                         core_mal_error,
   input  logic [2*NUM_DIGS-1:0]        core_err_digs,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_DIGS*DIG_W-1:0]    out_digs,
   output logic [2:0]                   out_flags,
   output logic [2*NUM_DIGS-1:0]        out_err_digs,
   output logic [CNT_W-1:0]             cnt_cor,
   output logic [CNT_W-1:0]             cnt_noncor,
   output logic [CNT_W-1:0]             cnt_mal,
   output logic [2*NUM_DIGS-1:0]        first_err_digs,
   output logic                         first_err_vld,
   output logic                         irq,
   output logic                         sync_err
);

   localparam int DW = NUM_DIGS * DIG_W;
   localparam int EW = 2 * NUM_DIGS;
   localparam int FW = DW + 3 + EW;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

   logic                r_rst_done;
   logic [CW-1:0]       r_inflight;
   logic [CORE_LAT-1:0] r_dl_vld;
   ec_mode_e            r_dl_mode [CORE_LAT];
   logic [DW-1:0]       r_dl_digs [CORE_LAT];
   logic [CNT_W-1:0]    r_cnt_cor, r_cnt_noncor, r_cnt_mal;
   logic [EW-1:0]       r_first_digs;
   logic                r_first_vld, r_irq, r_sync_err;

   logic [CW-1:0]       w_fifo_count;
   logic [CW:0]         w_credit_used;
   logic                w_in_ready, w_accept, w_fifo_empty;
   logic                w_em_vld, w_bypass, w_bad, w_drop, w_fifo_wr, w_stat;
   ec_mode_e            w_em_mode;
   logic [2:0]          w_flags;
   logic [EW-1:0]       w_err;
   logic [DW-1:0]       w_sel_digs;
   logic [FW-1:0]       w_fifo_wdata, w_fifo_rdata;

   // Both ports use valid/ready: a transfer happens on a rising edge where valid and
   // ready are both high. Credits cover every word in the delay line plus the FIFO,
   // so the non-stallable core can never overrun the output buffer.
   assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign w_in_ready    = r_rst_done & (w_credit_used < LP_DEPTH);
   assign w_accept      = in_valid & w_in_ready;

   assign in_ready   = w_in_ready;
   assign core_valid = w_accept;
   assign core_digs  = in_digs;

   assign w_em_vld   = r_dl_vld[CORE_LAT-1];
   assign w_em_mode  = r_dl_mode[CORE_LAT-1];
   assign w_bypass   = (w_em_mode == MODE_BYPASS);
   assign w_flags    = w_bypass ? 3'b000
                                : {core_mal_error, core_non_cor_error, core_cor_error};
   assign w_err      = w_bypass ? '0 : core_err_digs;
   assign w_sel_digs = (w_em_mode == MODE_DETECT || w_bypass) ? r_dl_digs[CORE_LAT-1]
                                                              : core_out_digs;
   assign w_bad      = w_flags[FLG_NONCOR] | w_flags[FLG_MAL];
   assign w_drop     = (w_em_mode == MODE_DROP_BAD) & w_bad;
   assign w_fifo_wr  = w_em_vld & ~w_drop;
   assign w_stat     = w_em_vld & ~w_bypass;
   assign w_fifo_wdata = {w_sel_digs, w_flags, w_err};

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_rst_done <= 1'b0;
         r_inflight <= '0;
         r_dl_vld   <= '0;
      end else begin
         r_rst_done  <= 1'b1;
         r_dl_vld[0] <= w_accept;
         for (int i = 1; i < CORE_LAT; i++) r_dl_vld[i] <= r_dl_vld[i-1];
         case ({w_accept, w_em_vld})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      r_dl_mode[0] <= ec_mode_e'(mode);
      r_dl_digs[0] <= in_digs;
      for (int i = 1; i < CORE_LAT; i++) begin
         r_dl_mode[i] <= r_dl_mode[i-1];
         r_dl_digs[i] <= r_dl_digs[i-1];
      end
   end

   // Sync check is masked while the line is empty so stale core pulses after reset are ignored.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_cnt_cor    <= '0;
         r_cnt_noncor <= '0;
         r_cnt_mal    <= '0;
         r_first_digs <= '0;
         r_first_vld  <= 1'b0;
         r_irq        <= 1'b0;
         r_sync_err   <= 1'b0;
      end else if (clr_stats) begin
         r_cnt_cor    <= '0;
         r_cnt_noncor <= '0;
         r_cnt_mal    <= '0;
         r_first_digs <= '0;
         r_first_vld  <= 1'b0;
         r_irq        <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         if (w_stat && w_flags[FLG_COR] && (r_cnt_cor != '1))
            r_cnt_cor <= r_cnt_cor + CNT_W'(1);
         if (w_stat && w_flags[FLG_NONCOR] && (r_cnt_noncor != '1))
            r_cnt_noncor <= r_cnt_noncor + CNT_W'(1);
         if (w_stat && w_flags[FLG_MAL] && (r_cnt_mal != '1))
            r_cnt_mal <= r_cnt_mal + CNT_W'(1);
         if (w_stat && (w_flags != 3'b000) && !r_first_vld) begin
            r_first_vld  <= 1'b1;
            r_first_digs <= w_err;
         end
         if (w_stat && w_bad) r_irq <= 1'b1;
         if ((r_dl_vld != '0) && (core_valid_out != w_em_vld)) r_sync_err <= 1'b1;
      end
   end

   ec_stream_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data (w_fifo_wdata),
      .i_rd_en   (out_ready),
      .o_rd_data (w_fifo_rdata),
      .o_empty   (w_fifo_empty),
      .o_count   (w_fifo_count)
   );

   assign out_valid      = ~w_fifo_empty;
   assign out_digs       = w_fifo_rdata[FW-1:EW+3];
   assign out_flags      = w_fifo_rdata[EW+2:EW];
   assign out_err_digs   = w_fifo_rdata[EW-1:0];
   assign cnt_cor        = r_cnt_cor;
   assign cnt_noncor     = r_cnt_noncor;
   assign cnt_mal        = r_cnt_mal;
   assign first_err_digs = r_first_digs;
   assign first_err_vld  = r_first_vld;
   assign irq            = r_irq;
   assign sync_err       = r_sync_err;

endmodule

// File: tb/tb_ec_correct_stream_ctrl.sv
// Directed scenarios with random word contents, a latency-4 model core and an
// in-order scoreboard plus a statistics model derived from the stream rules.
module tb_ec_correct_stream_ctrl;
   import ec_stream_pkg::*;

   localparam int ND   = 10;
   localparam int DGW  = 18;
   localparam int LAT  = 4;
   localparam int FD   = 8;
   localparam int CW   = 4;
   localparam int DW   = ND * DGW;
   localparam int EW   = 2 * ND;
   localparam int MAXW = 256;
   localparam int SAT  = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           aclr_n;
   logic [1:0]     mode;
   logic           clr_stats;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_digs;
   logic           core_valid;
   logic [DW-1:0]  core_digs;
   logic           core_valid_out;
   logic [DW-1:0]  core_out_digs;
   logic           core_cor_error, core_non_cor_error, core_mal_error;
   logic [EW-1:0]  core_err_digs;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_digs;
   logic [2:0]     out_flags;
   logic [EW-1:0]  out_err_digs;
   logic [CW-1:0]  cnt_cor, cnt_noncor, cnt_mal;
   logic [EW-1:0]  first_err_digs;
   logic           first_err_vld, irq, sync_err;

   always #5 clk = ~clk;

   ec_correct_stream_ctrl #(
      .NUM_DIGS (ND), .DIG_W (DGW), .CORE_LAT (LAT), .FIFO_DEPTH (FD), .CNT_W (CW)
   ) dut (
      .clk (clk), .aclr_n (aclr_n), .mode (mode), .clr_stats (clr_stats),
      .in_valid (in_valid), .in_ready (in_ready), .in_digs (in_digs),
      .core_valid (core_valid), .core_digs (core_digs),
      .core_valid_out (core_valid_out), .core_out_digs (core_out_digs),
      .core_cor_error (core_cor_error), .core_non_cor_error (core_non_cor_error),
      .core_mal_error (core_mal_error), .core_err_digs (core_err_digs),
      .out_valid (out_valid), .out_ready (out_ready), .out_digs (out_digs),
      .out_flags (out_flags), .out_err_digs (out_err_digs),
      .cnt_cor (cnt_cor), .cnt_noncor (cnt_noncor), .cnt_mal (cnt_mal),
      .first_err_digs (first_err_digs), .first_err_vld (first_err_vld),
      .irq (irq), .sync_err (sync_err)
   );

   // per-word attributes, indexed by acceptance order
   logic [DW-1:0] wd_raw  [MAXW];
   logic [DW-1:0] wd_corr [MAXW];
   logic [2:0]    wd_flg  [MAXW];
   logic [EW-1:0] wd_err  [MAXW];
   logic          wd_skip [MAXW];
   logic [1:0]    wd_mode [MAXW];

   // model core: fixed latency, not reset (it keeps emitting after a controller reset)
   int             drv_id = 0;
   logic [LAT-1:0] cm_v = '0;
   int             cm_id [LAT] = '{default: 0};

   always @(posedge clk) begin
      cm_v     <= {cm_v[LAT-2:0], core_valid};
      cm_id[0] <= drv_id;
      for (int i = 1; i < LAT; i++) cm_id[i] <= cm_id[i-1];
   end

   assign core_valid_out     = cm_v[LAT-1] & ~wd_skip[cm_id[LAT-1]];
   assign core_out_digs      = wd_corr[cm_id[LAT-1]];
   assign core_cor_error     = wd_flg[cm_id[LAT-1]][0];
   assign core_non_cor_error = wd_flg[cm_id[LAT-1]][1];
   assign core_mal_error     = wd_flg[cm_id[LAT-1]][2];
   assign core_err_digs      = wd_err[cm_id[LAT-1]];

   // scoreboard and reference model state
   logic [DW+3+EW-1:0] exp_q [$];
   int                 acc_q [$];
   int  n_chk = 0, n_err = 0;
   int  cyc = 0, next_id = 0, send_left = 0, n_acc = 0, n_out = 0, last_acc = 0;
   logic rdy_drv = 1'b0, chk_lat = 1'b0;
   int   m_cor = 0, m_noncor = 0, m_mal = 0;
   logic [EW-1:0] m_first = '0;
   logic m_first_vld = 1'b0, m_irq = 1'b0, m_sync = 1'b0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_cor = 0; m_noncor = 0; m_mal = 0;
      m_first = '0; m_first_vld = 1'b0; m_irq = 1'b0; m_sync = 1'b0;
   endtask

   task automatic gen(input int id, input logic [1:0] m, input logic [2:0] f, input logic sk);
      for (int d = 0; d < ND; d++) begin
         wd_raw[id][d*DGW +: DGW]  = DGW'($urandom);
         wd_corr[id][d*DGW +: DGW] = DGW'($urandom);
      end
      wd_flg[id]  = f;
      wd_err[id]  = (f == 3'b000) ? '0 : EW'($urandom_range(1, (1 << EW) - 1));
      wd_skip[id] = sk;
      wd_mode[id] = m;
   endtask

   task automatic model_accept(input int id);
      logic          byp, bad;
      logic [2:0]    f;
      logic [EW-1:0] e;
      logic [DW-1:0] d;
      byp = (wd_mode[id] == 2'd2);
      f   = byp ? 3'b000 : wd_flg[id];
      e   = byp ? '0 : wd_err[id];
      d   = (wd_mode[id] == 2'd1 || byp) ? wd_raw[id] : wd_corr[id];
      bad = f[1] | f[2];
      if (!(wd_mode[id] == 2'd3 && bad)) begin
         exp_q.push_back({d, f, e});
         acc_q.push_back(cyc);
      end
      if (f[0]) m_cor    = (m_cor    < SAT) ? m_cor + 1    : SAT;
      if (f[1]) m_noncor = (m_noncor < SAT) ? m_noncor + 1 : SAT;
      if (f[2]) m_mal    = (m_mal    < SAT) ? m_mal + 1    : SAT;
      if (f != 3'b000 && !m_first_vld) begin
         m_first_vld = 1'b1;
         m_first     = e;
      end
      if (bad) m_irq = 1'b1;
      if (wd_skip[id]) m_sync = 1'b1;
   endtask

   task automatic check_out();
      int a;
      if (exp_q.size() == 0) begin
         chk("spurious_out", out_valid, 1'b0);
      end else begin
         a = acc_q.pop_front();
         chk("out_word", {out_digs, out_flags, out_err_digs}, exp_q.pop_front());
         if (chk_lat) chk("latency", cyc - a, LAT + 1);
      end
      n_out++;
   endtask

   // one clock: drive at the falling edge, then note handshakes that complete at the next rise
   task automatic step();
      @(negedge clk);
      cyc++;
      out_ready = rdy_drv;
      if (send_left > 0) begin
         drv_id   = next_id;
         in_valid = 1'b1;
         in_digs  = wd_raw[next_id];
         mode     = wd_mode[next_id];
      end else begin
         in_valid = 1'b0;
      end
      if (out_valid && out_ready) check_out();
      if (in_valid && chk_lat) chk("core_digs", core_digs, in_digs);
      if (in_valid && in_ready) begin
         model_accept(next_id);
         last_acc = cyc;
         next_id++;
         send_left--;
         n_acc++;
      end
   endtask

   task automatic send_all(input int budget);
      int k = 0;
      while (send_left > 0 && k < budget) begin step(); k++; end
      chk("send_timeout", send_left, 0);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (exp_q.size() > 0 && k < budget) begin step(); k++; end
      chk("drain_timeout", exp_q.size(), 0);
      repeat (LAT + 2) step();
   endtask

   task automatic chk_stats(input string tag);
      chk({tag, "_cnt_cor"}, cnt_cor, m_cor);
      chk({tag, "_cnt_noncor"}, cnt_noncor, m_noncor);
      chk({tag, "_cnt_mal"}, cnt_mal, m_mal);
      chk({tag, "_first_vld"}, first_err_vld, m_first_vld);
      chk({tag, "_first_digs"}, first_err_digs, m_first);
      chk({tag, "_irq"}, irq, m_irq);
      chk({tag, "_sync_err"}, sync_err, m_sync);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int base, outs0;
      for (int i = 0; i < MAXW; i++) gen(i, 2'd0, 3'b000, 1'b0);
      aclr_n = 1'b0; clr_stats = 1'b0; in_valid = 1'b0; mode = 2'd0;
      in_digs = '0; out_ready = 1'b0;

      // reset state
      step(); step();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk_stats("rst");
      aclr_n = 1'b1;
      step();
      chk("in_ready_after_release", in_ready, 1'b1);

      // 1: clean CORRECT stream with fixed latency
      base = next_id;
      for (int i = 0; i < 20; i++) gen(base + i, 2'd0, 3'b000, 1'b0);
      rdy_drv = 1'b1; chk_lat = 1'b1; send_left = 20;
      send_all(100); drain(100);
      chk_lat = 1'b0;
      chk_stats("clean");
      chk("clean_flags_last", out_flags, 3'b000);

      // 2: backpressure limits acceptance to FIFO_DEPTH words
      base = next_id;
      for (int i = 0; i < 12; i++) gen(base + i, 2'd0, 3'b000, 1'b0);
      rdy_drv = 1'b0; n_acc = 0; outs0 = n_out; send_left = 12;
      repeat (20) step();
      chk("bp_accepted", n_acc, FD);
      chk("bp_in_ready_low", in_ready, 1'b0);
      rdy_drv = 1'b1;
      send_all(100); drain(100);
      chk("bp_total_accepted", n_acc, 12);
      chk("bp_total_out", n_out - outs0, 12);

      // 3: correctable error capture, then saturation
      base = next_id;
      for (int i = 0; i < 5; i++) gen(base + i, 2'd0, (i == 3) ? 3'b001 : 3'b000, 1'b0);
      wd_err[base + 3] = 20'h0000C;
      send_left = 5; send_all(100); drain(100);
      chk("cor_cnt_one", cnt_cor, 1);
      chk("cor_first", first_err_digs, 20'h0000C);
      chk_stats("cor");
      base = next_id;
      for (int i = 0; i < 20; i++) gen(base + i, 2'd0, 3'b001, 1'b0);
      send_left = 20; send_all(100); drain(100);
      chk("cor_saturated", cnt_cor, SAT);
      chk_stats("cor_sat");

      // 4: DROP_BAD discards an uncorrectable word, then clr_stats
      base = next_id; outs0 = n_out;
      for (int i = 0; i < 5; i++) gen(base + i, 2'd3, (i == 2) ? 3'b010 : 3'b000, 1'b0);
      send_left = 5; send_all(100); drain(100);
      chk("drop_out_count", n_out - outs0, 4);
      chk_stats("drop");
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      model_clear();
      step();
      chk_stats("clr");

      // clear coinciding with a malformed word's statistics update
      base = next_id;
      gen(base, 2'd0, 3'b100, 1'b0);
      send_left = 1; send_all(20);
      while (cyc < last_acc + LAT) step();
      clr_stats = 1'b1; step(); clr_stats = 1'b0;
      model_clear();
      drain(50);
      chk_stats("clr_wins");

      // 5: CORRECT -> DETECT -> BYPASS per word
      base = next_id;
      for (int i = 0; i < 9; i++)
         gen(base + i, (i < 3) ? 2'd0 : (i < 6) ? 2'd1 : 2'd2,
             (i == 1 || i == 3 || i == 4 || i == 6) ? 3'b001 : (i == 7) ? 3'b101 : 3'b000,
             1'b0);
      send_left = 9; send_all(100); drain(100);
      chk("modes_cnt_cor", cnt_cor, 3);
      chk_stats("modes");

      // 6: core drops one valid -> sticky sync_err
      base = next_id;
      for (int i = 0; i < 8; i++) gen(base + i, 2'd0, 3'b000, (i == 4));
      send_left = 8; send_all(100); drain(100);
      chk("sync_set", sync_err, 1'b1);
      base = next_id;
      for (int i = 0; i < 3; i++) gen(base + i, 2'd0, 3'b000, 1'b0);
      send_left = 3; send_all(100); drain(100);
      chk_stats("sync_sticky");

      // reset in the middle of a buffered stream
      base = next_id;
      for (int i = 0; i < 10; i++) gen(base + i, 2'd0, 3'b010, 1'b0);
      rdy_drv = 1'b0; send_left = 10;
      repeat (6) step();
      send_left = 0; step();
      aclr_n = 1'b0;
      exp_q.delete(); acc_q.delete(); model_clear();
      step();
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk_stats("mid_rst");
      step();
      aclr_n = 1'b1;
      chk("release_in_ready", in_ready, 1'b0);
      step();
      chk("post_release_in_ready", in_ready, 1'b1);
      rdy_drv = 1'b1;
      repeat (8) step();
      chk("no_stale_out", out_valid, 1'b0);
      base = next_id;
      for (int i = 0; i < 6; i++) gen(base + i, 2'd1, (i == 2) ? 3'b001 : 3'b000, 1'b0);
      send_left = 6; send_all(100); drain(100);
      chk_stats("after_rst");
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
